alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_issue_ctrl_if.sv | 45 ++++
 rtl/alu_regfile.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 112 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcodes, FSM states and instruction fields for the ALU issue path
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OP_W-1:0] OP_ROTL  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b011;
    localparam logic [OP_W-1:0] OP_OR    = 3'b100;
    localparam logic [OP_W-1:0] OP_AND   = 3'b101;
    localparam logic [OP_W-1:0] OP_MISC  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Register indices depend on NREGS and are held separately by the controller.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              useImm;
        logic [DATA_W-1:0] imm;
    } instr_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
// ============================================================================
// Module  : alu_issue_ctrl_if
// Brief   : Instruction, ALU and result handshake bundle of the issue controller
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_issue_ctrl_if #(
    parameter int RIDX_W = 2
);
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in_op;
    logic [RIDX_W-1:0]   in_rd;
    logic [RIDX_W-1:0]   in_rs1;
    logic [RIDX_W-1:0]   in_rs2;
    logic                in_use_imm;
    logic [DATA_W-1:0]   in_imm;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OP_W-1:0]     alu_op;
    logic [DATA_W-1:0]   alu_out;
    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;
    logic [RIDX_W-1:0]   res_rd;

    // The master side is the parent: it produces instructions, hosts the ALU and sinks results.
    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        output alu_out, res_ready,
        input  in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_rd
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        input  alu_out, res_ready,
        output in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_rd
    );

endinterface

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// Module  : alu_regfile
// Brief   : NREGS x 8 register file, two asynchronous reads, one synchronous write
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS  = 4,
    parameter int RIDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wrEn,
    input  logic [RIDX_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [RIDX_W-1:0] i_rdAddrA,
    output logic [DATA_W-1:0] o_rdDataA,
    input  logic [RIDX_W-1:0] i_rdAddrB,
    output logic [DATA_W-1:0] o_rdDataB
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Reset wins over a coincident write so an aborted instruction never commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdDataA = r_mem[i_rdAddrA];
    assign o_rdDataB = r_mem[i_rdAddrB];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Issue/writeback sequencer around a combinational 8-bit ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS  = 4,
    parameter int RIDX_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus
);

    state_t            r_state;
    instr_t            r_instr;
    logic [RIDX_W-1:0] r_rd;
    logic [RIDX_W-1:0] r_rs1;
    logic [RIDX_W-1:0] r_rs2;
    logic              r_inReady;
    logic              r_resValid;
    logic [DATA_W-1:0] r_resData;
    logic [RIDX_W-1:0] r_resRd;

    logic              w_exec;
    logic              w_wrEn;
    logic [DATA_W-1:0] w_rdA;
    logic [DATA_W-1:0] w_rdB;
    logic [DATA_W-1:0] w_opB;

    assign w_exec = (r_state == ST_EXEC);
    assign w_wrEn = w_exec;
    assign w_opB  = r_instr.useImm ? r_instr.imm : w_rdB;

    alu_regfile #(
        .NREGS  (NREGS),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_wrEn    (w_wrEn),
        .i_wrAddr  (r_rd),
        .i_wrData  (bus.alu_out),
        .i_rdAddrA (r_rs1),
        .o_rdDataA (w_rdA),
        .i_rdAddrB (r_rs2),
        .o_rdDataB (w_rdB)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_instr    <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_inReady  <= 1'b1;
            r_resValid <= 1'b0;
            r_resData  <= '0;
            r_resRd    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_inReady) begin
                        r_instr.op     <= bus.in_op;
                        r_instr.useImm <= bus.in_use_imm;
                        r_instr.imm    <= bus.in_imm;
                        r_rd           <= bus.in_rd;
                        r_rs1          <= bus.in_rs1;
                        r_rs2          <= bus.in_rs2;
                        r_inReady      <= 1'b0;
                        r_state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_resData  <= bus.alu_out;
                    r_resRd    <= r_rd;
                    r_resValid <= 1'b1;
                    r_state    <= ST_WB;
                end
                ST_WB: begin
                    if (bus.res_ready) begin
                        r_resValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_inReady  <= 1'b1;
                    r_resValid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Operands are only presented during EXEC; the ALU sees zeros otherwise.
    assign bus.alu_a     = w_exec ? w_rdA : '0;
    assign bus.alu_b     = w_exec ? w_opB : '0;
    assign bus.alu_op    = w_exec ? r_instr.op : '0;
    assign bus.in_ready  = r_inReady;
    assign bus.res_valid = r_resValid;
    assign bus.res_data  = r_resData;
    assign bus.res_rd    = r_resRd;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed plus random checks of alu_issue_ctrl against a register-array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nPass   = 0;
    logic [7:0] refR [4];

    alu_issue_ctrl_if #(.RIDX_W(2)) bus ();

    alu_issue_ctrl #(
        .NREGS  (4),
        .RIDX_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] aluRef(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [2:0] s;
        s = b[2:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_ROTL: return (s == 3'd0) ? a : ((a << s) | (a >> (4'd8 - {1'b0, s})));
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_MISC: return ~a;
            default: return a;
        endcase
    endfunction

    // Stand-in for the parent's combinational ALU.
    always_comb bus.alu_out = aluRef(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic useImm, input logic [7:0] imm);
        bus.in_op      = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_use_imm = useImm;
        bus.in_imm     = imm;
        bus.in_valid   = 1'b1;
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    endtask

    // One full instruction: accept, EXEC operands, result 2 cycles later, optional backpressure.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic useImm, input logic [7:0] imm, input int hold);
        logic [7:0] a, b, exp;
        a   = refR[rs1];
        b   = useImm ? imm : refR[rs2];
        exp = aluRef(op, a, b);
        drive(op, rd, rs1, rs2, useImm, imm);
        waitReady();
        tick();
        bus.in_valid = 1'b0;
        check("exec_alu_a", bus.alu_a, a);
        check("exec_alu_b", bus.alu_b, b);
        check("exec_alu_op", bus.alu_op, op);
        check("exec_in_ready", bus.in_ready, 0);
        check("exec_res_valid", bus.res_valid, 0);
        tick();
        check("wb_res_valid", bus.res_valid, 1);
        check("wb_res_data", bus.res_data, exp);
        check("wb_res_rd", bus.res_rd, rd);
        check("wb_alu_op_zero", bus.alu_op, 0);
        refR[rd] = exp;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_res_valid", bus.res_valid, 1);
            check("hold_res_data", bus.res_data, exp);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("idle_res_valid", bus.res_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a1, exp1, a2, b2, exp2;
        bus.in_valid   = 1'b0;
        bus.res_ready  = 1'b0;
        bus.in_op      = '0;
        bus.in_rd      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = '0;
        for (int i = 0; i < 4; i++) refR[i] = 8'h00;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_rd", bus.res_rd, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_op", bus.alu_op, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) issue(OP_PASSA, 2'(i), 2'(i), 2'd0, 1'b0, 8'h00, 0);

        issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0);
        issue(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'hFD, 0);
        issue(OP_SUB, 2'd3, 2'd2, 2'd0, 1'b1, 8'h01, 0);
        issue(OP_PASSA, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 0);
        issue(OP_ADD, 2'd0, 2'd2, 2'd0, 1'b1, 8'h81, 0);
        issue(OP_ADD, 2'd1, 2'd2, 2'd0, 1'b1, 8'h03, 0);
        issue(OP_ROTL, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 0);

        // Backpressure: second instruction stays on the bus while the first is stuck in WB.
        a1   = refR[0];
        exp1 = aluRef(OP_OR, a1, 8'h30);
        drive(OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 8'h30);
        waitReady();
        tick();
        drive(OP_AND, 2'd2, 2'd3, 2'd0, 1'b0, 8'h00);
        check("bp_exec_in_ready", bus.in_ready, 0);
        tick();
        refR[3] = exp1;
        for (int k = 0; k < 5; k++) begin
            check("bp_res_valid", bus.res_valid, 1);
            check("bp_res_data", bus.res_data, exp1);
            check("bp_res_rd", bus.res_rd, 3);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_alu_op_zero", bus.alu_op, 0);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_idle_res_valid", bus.res_valid, 0);
        check("bp_idle_in_ready", bus.in_ready, 1);
        a2   = refR[3];
        b2   = refR[0];
        exp2 = aluRef(OP_AND, a2, b2);
        tick();
        bus.in_valid = 1'b0;
        check("bp2_exec_op", bus.alu_op, OP_AND);
        check("bp2_exec_a", bus.alu_a, a2);
        check("bp2_exec_b", bus.alu_b, b2);
        tick();
        check("bp2_res_valid", bus.res_valid, 1);
        check("bp2_res_data", bus.res_data, exp2);
        check("bp2_res_rd", bus.res_rd, 2);
        refR[2] = exp2;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Reset during EXEC discards the write.
        drive(OP_XOR, 2'd2, 2'd0, 2'd0, 1'b1, 8'h5A);
        waitReady();
        tick();
        bus.in_valid = 1'b0;
        check("abort_exec_op", bus.alu_op, OP_XOR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) refR[i] = 8'h00;
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_alu_op", bus.alu_op, 0);
        issue(OP_PASSA, 2'd2, 2'd2, 2'd0, 1'b0, 8'h00, 0);
        issue(OP_PASSA, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 0);

        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 4; i++) issue(OP_PASSA, 2'(i), 2'(i), 2'd0, 1'b0, 8'h00, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
